// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the four-phase req/ack clock-domain crossing.
//   state_e     : sender FSM encoding (IDLE / REQ / DROP)
//   ERR_*       : bit positions inside the sticky error vector
//   cnt_width() : width of a saturating wait counter able to hold 0..t
// -----------------------------------------------------------------------------
package cdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam int unsigned ERR_TIMEOUT = 0;
    localparam int unsigned ERR_PROTO   = 1;
    localparam int unsigned ERR_BITS    = 2;

    // A zero limit still needs a 1-bit counter so the vector stays legal.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage : cdc_pkg

// File: rtl/sync_ff_chain.sv
// -----------------------------------------------------------------------------
// sync_ff_chain
// N-stage single-bit synchronizer. The first flop may go metastable; the
// remaining STAGES-1 flops give it time to resolve. STAGES must be >= 2.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (all stages clear to 0)
//   d_i    : asynchronous input bit
//   q_o    : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sync_ff_chain

// File: rtl/cdc_req_sender.sv
// -----------------------------------------------------------------------------
// cdc_req_sender
// Source-domain launcher of a four-phase req/ack crossing. A word accepted on
// the valid/ready interface is held on data_hold while req is raised; the
// next word is accepted only after the synchronized ack has risen and fallen.
// Ports:
//   clk_src   : source clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream word available
//   in_ready  : block can accept a word (state is IDLE)
//   in_data   : upstream word
//   req       : registered level request to the destination domain
//   data_hold : registered held word, stable while req or ack is pending
//   ack_async : raw acknowledge from the destination domain
//   busy      : a transfer is in progress
//   err       : sticky flags, [0] timeout, [1] protocol violation
//   err_clr   : single-cycle clear of err (a simultaneous set wins)
// -----------------------------------------------------------------------------
module cdc_req_sender
    import cdc_pkg::*;
#(
    parameter int unsigned BITS_WIDTH     = 5,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_src,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS_WIDTH-1:0] in_data,
    output logic                  req,
    output logic [BITS_WIDTH-1:0] data_hold,
    input  logic                  ack_async,
    output logic                  busy,
    output logic [ERR_BITS-1:0]   err,
    input  logic                  err_clr
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic                  ack_sync;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [BITS_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ERR_BITS-1:0]   err_q, err_d;
    logic                  waiting;
    logic                  timeout_hit;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i  (clk_src),
        .rst_ni (rst_n),
        .d_i    (ack_async),
        .q_o    (ack_sync)
    );

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        waiting     = 1'b0;
        timeout_hit = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    data_d  = in_data;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                if (ack_sync) begin
                    state_d = ST_DROP;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_DROP: begin
                if (!ack_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    waiting = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Saturate at the limit; the FSM keeps waiting so the handshake
        // can never be abandoned half way.
        if (waiting && (cnt_q < CNT_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (TIMEOUT_EN && waiting && (cnt_d == CNT_LIMIT)) begin
            timeout_hit = 1'b1;
        end

        // Clear first so a set in the same cycle overrides it.
        if (err_clr) begin
            err_d = '0;
        end
        if (timeout_hit) begin
            err_d[ERR_TIMEOUT] = 1'b1;
        end
        if ((state_q == ST_IDLE) && ack_sync) begin
            err_d[ERR_PROTO] = 1'b1;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign req       = req_q;
    assign data_hold = data_q;
    assign err       = err_q;

endmodule : cdc_req_sender

// File: tb/tb_cdc_req_sender.sv
module tb_cdc_req_sender;
    import cdc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    // Instance A: default parameters (SYNC_STAGES=2, TIMEOUT_CYCLES=255)
    logic       va, ra, reqa, acka, busya, clra;
    logic [4:0] da, dha;
    logic [1:0] erra;
    logic       loop_a, acka_drv;
    // Instance B: TIMEOUT_CYCLES=8
    logic       vb, rb, reqb, ackb, busyb, clrb;
    logic [4:0] db, dhb;
    logic [1:0] errb;

    logic [4:0] sbq[$];
    logic       prev_req = 1'b0;

    assign acka = loop_a ? reqa : acka_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cdc_req_sender #(
        .BITS_WIDTH     (5),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (255)
    ) dut_a (
        .clk_src   (clk),
        .rst_n     (rst_n),
        .in_valid  (va),
        .in_ready  (ra),
        .in_data   (da),
        .req       (reqa),
        .data_hold (dha),
        .ack_async (acka),
        .busy      (busya),
        .err       (erra),
        .err_clr   (clra)
    );

    cdc_req_sender #(
        .BITS_WIDTH     (5),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (8)
    ) dut_b (
        .clk_src   (clk),
        .rst_n     (rst_n),
        .in_valid  (vb),
        .in_ready  (rb),
        .in_data   (db),
        .req       (reqb),
        .data_hold (dhb),
        .ack_async (ackb),
        .busy      (busyb),
        .err       (errb),
        .err_clr   (clrb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return reqa;
            1:       return ra;
            2:       return reqb;
            default: return rb;
        endcase
    endfunction

    // Bounded wait at negedges for a signal level; expiry counts as a failure.
    task automatic wait_sig(input string tag, input int which, input logic lvl);
        for (int i = 0; i < 200; i++) begin
            if (sel(which) === lvl) return;
            @(negedge clk);
        end
        check(tag, 32'(sel(which)), 32'(lvl));
    endtask

    // Scoreboard: each rising req on instance A must present the next expected word.
    always @(negedge clk) begin
        if (reqa && !prev_req) begin
            if (sbq.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else                 check("sb_word", 32'(dha), 32'(sbq.pop_front()));
        end
        prev_req = reqa;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, hi;
        rst_n = 1'b0; va = 0; da = '0; clra = 0; loop_a = 0; acka_drv = 0;
        vb = 0; db = '0; clrb = 0; ackb = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ra), 32'd1);
        check("rst_busy", 32'(busya), 32'd0);
        check("rst_req", 32'(reqa), 32'd0);
        check("rst_err", 32'(erra), 32'd0);
        check("rst_hold", 32'(dha), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Loopback, two words back to back with in_valid held high
        loop_a = 1;
        va = 1; da = 5'h15; sbq.push_back(5'h15);
        wait_sig("lb_req1", 0, 1'b1);
        t1 = cyc;
        da = 5'h0A; sbq.push_back(5'h0A);
        hi = 0;
        while (reqa && hi < 50) begin
            check("lb_hold_hi", 32'(dha), 32'h15);
            hi++;
            @(negedge clk);
        end
        check("lb_req_hi_cycles", 32'(hi), 32'd3);
        for (int i = 0; i < 50 && !reqa; i++) begin
            check("lb_hold_lo", 32'(dha), 32'h15);
            @(negedge clk);
        end
        wait_sig("lb_req2", 0, 1'b1);
        t2 = cyc;
        va = 0;
        check("lb_accept_gap", 32'(t2 - t1), 32'd7);
        wait_sig("lb_ready", 1, 1'b1);
        check("lb_ready_lat", 32'(cyc - t2), 32'd6);
        check("lb_hold2", 32'(dha), 32'h0A);
        loop_a = 0;
        @(negedge clk);

        // Delayed ack: 20 cycles to rise, 10 cycles after req falls to drop
        va = 1; da = 5'h07; sbq.push_back(5'h07);
        wait_sig("dl_req", 0, 1'b1);
        va = 0;
        repeat (20) @(negedge clk);
        check("dl_req_still", 32'(reqa), 32'd1);
        acka_drv = 1;
        wait_sig("dl_req_fall", 0, 1'b0);
        check("dl_busy_drop", 32'(busya), 32'd1);
        repeat (10) @(negedge clk);
        acka_drv = 0;
        wait_sig("dl_ready", 1, 1'b1);
        check("dl_err", 32'(erra), 32'd0);
        check("dl_hold", 32'(dha), 32'h07);

        // Timeout on instance B (limit 8)
        vb = 1; db = 5'h1F;
        @(negedge clk);
        check("to_req", 32'(reqb), 32'd1);
        vb = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("to_err0", 32'(errb[0]), (k == 8) ? 32'd1 : 32'd0);
        end
        check("to_req_held", 32'(reqb), 32'd1);
        repeat (5) @(negedge clk);
        check("to_err_sticky", 32'(errb), 32'd1);
        ackb = 1;
        wait_sig("to_req_fall", 2, 1'b0);
        ackb = 0;
        wait_sig("to_ready", 3, 1'b1);
        check("to_err_after", 32'(errb), 32'd1);
        check("to_hold", 32'(dhb), 32'h1F);
        clrb = 1;
        @(negedge clk);
        clrb = 0;
        check("to_clr", 32'(errb), 32'd0);

        // Protocol violation: ack while idle
        acka_drv = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("pv_err1", 32'(erra[1]), (k == 3) ? 32'd1 : 32'd0);
        end
        clra = 1;
        @(negedge clk);
        clra = 0;
        check("pv_set_wins", 32'(erra), 32'd2);
        check("pv_ready", 32'(ra), 32'd1);
        acka_drv = 0;
        repeat (4) @(negedge clk);

        // Reset mid-REQ
        va = 1; da = 5'h13; sbq.push_back(5'h13);
        wait_sig("rs_req", 0, 1'b1);
        va = 0;
        check("rs_pre_err", 32'(erra), 32'd2);
        check("rs_pre_hold", 32'(dha), 32'h13);
        rst_n = 1'b0;
        #1;
        check("rs_req", 32'(reqa), 32'd0);
        check("rs_busy", 32'(busya), 32'd0);
        check("rs_err", 32'(erra), 32'd0);
        check("rs_hold", 32'(dha), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_ready", 32'(ra), 32'd1);

        // in_valid pulse while busy is ignored
        loop_a = 1;
        va = 1; da = 5'h0C; sbq.push_back(5'h0C);
        wait_sig("bz_req", 0, 1'b1);
        va = 1; da = 5'h11;
        check("bz_ready0", 32'(ra), 32'd0);
        @(negedge clk);
        va = 0;
        check("bz_ready1", 32'(ra), 32'd0);
        check("bz_hold", 32'(dha), 32'h0C);
        wait_sig("bz_ready", 1, 1'b1);
        check("bz_hold_end", 32'(dha), 32'h0C);
        loop_a = 0;
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cdc_req_sender

// File: doc/cdc_req_sender.md
# cdc_req_sender

Source-domain launcher for a four-phase req/ack clock-domain crossing. Accepts a word on a valid/ready interface, holds it stable on `data_hold`, raises a level `req` to the destination domain, and waits for the destination's raw `ack` (synchronized internally) to rise and then fall before accepting the next word. It is the sending end of the crossing; the destination-side capture block samples `data_hold` when it sees `req` and drives `ack`.

## Interface
- `BITS_WIDTH`, default 5: data word width.
- `SYNC_STAGES`, default 2: flops in the `ack` synchronizer chain; minimum 2.
- `TIMEOUT_CYCLES`, default 255: wait-cycle limit before the timeout flag is set; 0 disables the timeout.
- `clk_src` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream word available.
- `in_ready` out 1: block can accept a word.
- `in_data` in BITS_WIDTH: upstream word.
- `req` out 1: registered level request to the destination domain.
- `data_hold` out BITS_WIDTH: registered held word; stable whenever `req` is 1 or `ack` is pending.
- `ack_async` in 1: raw acknowledge from the destination domain; never used before synchronization.
- `busy` out 1: a transfer is in progress.
- `err` out 2: sticky error flags. Bit 0 is timeout; bit 1 is protocol violation.
- `err_clr` in 1: clears `err` (single-cycle pulse).

## Operation
- `ack_async` passes through SYNC_STAGES flops to give `ack_sync`. All synchronizer flops reset to 0.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready` at an edge, `data_hold` <= `in_data`, `req` <= 1, and the state goes to REQ.
  - REQ: holds until `ack_sync`=1. Then `req` <= 0 and the state goes to DROP.
  - DROP: holds until `ack_sync`=0. Then the state goes to IDLE.
- `in_ready` = (state==IDLE). `busy` = (state!=IDLE). `req` = 1 exactly while the state is REQ.
- `data_hold` loads only on accept; it is unchanged in REQ, DROP and IDLE otherwise.
- Timeout counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to REQ and on entry to DROP. Increments each cycle spent in REQ or DROP. Saturates.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), `err[0]` sets. The FSM keeps waiting and is never forced out, which preserves the four-phase safety.
- Protocol check: `ack_sync`=1 while in IDLE sets `err[1]`. The FSM ignores it and may still accept. If `ack_sync` is already 1 on entry to REQ, the block advances to DROP on the next edge.
- `err_clr` clears both bits. If a set condition and `err_clr` occur in the same cycle, set wins.
- Reset asserted at any time, mid-transfer included, takes effect immediately:
  - State goes to IDLE.
  - `req`=0, `data_hold`=0, `err`=0, counter=0, sync flops=0.
  - Outputs after reset: `in_ready`=1, `busy`=0.

## Timing
- Accept at edge N gives `req`=1 and the new `data_hold` from edge N onward.
- The `ack_async` rise is seen in `ack_sync` after SYNC_STAGES edges. `req` falls at the next edge after that.
- With `ack_async` looped back from `req` at zero delay:
  - `req` is high for SYNC_STAGES+1 cycles.
  - `in_ready` returns 2*SYNC_STAGES+2 edges after accept.
  - Back-to-back accepts are 2*SYNC_STAGES+3 edges apart (7 for the default).
- `in_ready` is a function of registered state only; there is no combinational path from `in_valid` or `ack_async` to any output.

## Structure
- Shared package `cdc_pkg` holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, DROP=2'd2);
  - the error bit indices (`ERR_TIMEOUT`=0, `ERR_PROTO`=1).
- One sub-module, `sync_ff_chain`: a parameterized N-stage single-bit synchronizer with async active-low reset, used for `ack_async`. The destination-side block reuses it for `req`.

## Test plan
- Reset mid-REQ (`req`=1): assert `rst_n`=0 -> `req`, `busy`, `err` and `data_hold` go to 0 immediately; `in_ready`=1 after release.
- Loopback `ack_async`=`req`, SYNC_STAGES=2, words 5'h15 then 5'h0A with `in_valid` held high:
  - `req` high for 3 cycles per word;
  - accepts 7 edges apart;
  - `data_hold`=5'h15 constant until the second accept.
- Delayed ack (bench raises ack 20 cycles after `req`, drops it 10 cycles after `req` falls), TIMEOUT_CYCLES=255 -> one transfer, `err`=2'b00.
- Ack never arrives, TIMEOUT_CYCLES=8 -> `err[0]`=1 at the 8th wait cycle, `req` stays 1. Then raise ack -> normal completion. `err_clr` -> `err`=0.
- `ack_async`=1 while IDLE -> `err[1]`=1 SYNC_STAGES+1 edges later. `err_clr` asserted in a cycle where the condition persists -> `err[1]` stays 1.
- `in_valid` pulse for 1 cycle while busy -> not accepted, `data_hold` unchanged, `in_ready`=0 throughout.
